// File: rtl/regfile_sb_if.sv
// Register-file bus: read ports, the two writeback lanes, issue marking and flush.
// The pipeline (decode/writeback/hazard side) is the master; the register file is the slave.
interface regfile_sb_if #(
   parameter int XLEN = 32,
   parameter int AW   = 5
);
   logic [AW-1:0]   rs1_addr;
   logic [AW-1:0]   rs2_addr;
   logic [XLEN-1:0] rs1_data;
   logic [XLEN-1:0] rs2_data;
   logic            rs1_busy;
   logic            rs2_busy;

   logic            wa_en;
   logic [AW-1:0]   wa_addr;
   logic [XLEN-1:0] wa_data;
   logic            wb_en;
   logic [AW-1:0]   wb_addr;
   logic [XLEN-1:0] wb_data;

   logic            iss_en;
   logic [AW-1:0]   iss_addr;
   logic            flush;

   modport master (
      output rs1_addr, rs2_addr,
      output wa_en, wa_addr, wa_data,
      output wb_en, wb_addr, wb_data,
      output iss_en, iss_addr, flush,
      input  rs1_data, rs2_data, rs1_busy, rs2_busy
   );

   modport slave (
      input  rs1_addr, rs2_addr,
      input  wa_en, wa_addr, wa_data,
      input  wb_en, wb_addr, wb_data,
      input  iss_en, iss_addr, flush,
      output rs1_data, rs2_data, rs1_busy, rs2_busy
   );
endinterface

// File: rtl/regfile_sb.sv
// Integer register file with two combinational read ports, two write lanes with
// same-cycle bypass, and a per-register pending bit; x0 is zero and never pending.
module regfile_sb #(
   parameter int XLEN   = 32,
   parameter int AW     = 5,
   parameter int BYPASS = 1
) (
   input logic         clk,
   input logic         rst,
   regfile_sb_if.slave rf
);
   localparam int NREG = 2 ** AW;
   localparam int NRD  = 2;

   genvar gi;

   logic [NREG-1:0][XLEN-1:0] regs_q;
   logic [NREG-1:0]           pend_q;
   logic [NREG-1:0]           wa_sel;
   logic [NREG-1:0]           wb_sel;
   logic [NREG-1:0]           iss_sel;

   logic [NRD-1:0][AW-1:0]    rd_addr;
   logic [NRD-1:0][XLEN-1:0]  rd_data;
   logic [NRD-1:0]            rd_busy;

   // Index 0 has no storage: it reads as zero and can never be selected.
   assign regs_q[0]  = '0;
   assign pend_q[0]  = 1'b0;
   assign wa_sel[0]  = 1'b0;
   assign wb_sel[0]  = 1'b0;
   assign iss_sel[0] = 1'b0;

   for (gi = 1; gi < NREG; gi++) begin : g_reg
      logic [XLEN-1:0] data_reg;
      logic            pend_reg;

      assign wa_sel[gi]  = rf.wa_en  && (rf.wa_addr  == AW'(gi));
      assign wb_sel[gi]  = rf.wb_en  && (rf.wb_addr  == AW'(gi));
      assign iss_sel[gi] = rf.iss_en && (rf.iss_addr == AW'(gi));

      // Lane B is the younger writeback and wins a same-address collision.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            data_reg <= '0;
         end else if (wb_sel[gi]) begin
            data_reg <= rf.wb_data;
         end else if (wa_sel[gi]) begin
            data_reg <= rf.wa_data;
         end
      end

      // A new producer outranks both a flush and a writeback of an older one.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            pend_reg <= 1'b0;
         end else if (iss_sel[gi]) begin
            pend_reg <= 1'b1;
         end else if (rf.flush) begin
            pend_reg <= 1'b0;
         end else if (wa_sel[gi] || wb_sel[gi]) begin
            pend_reg <= 1'b0;
         end
      end

      assign regs_q[gi] = data_reg;
      assign pend_q[gi] = pend_reg;
   end

   assign rd_addr[0] = rf.rs1_addr;
   assign rd_addr[1] = rf.rs2_addr;

   for (gi = 0; gi < NRD; gi++) begin : g_rd
      logic            wa_hit;
      logic            wb_hit;
      logic [XLEN-1:0] rd_val;
      logic            rd_pend;

      assign wa_hit = (BYPASS != 0) && rf.wa_en && (rf.wa_addr == rd_addr[gi]);
      assign wb_hit = (BYPASS != 0) && rf.wb_en && (rf.wb_addr == rd_addr[gi]);

      // Forwarded data makes the register usable now, so busy is masked too.
      always_comb begin
         rd_val  = regs_q[rd_addr[gi]];
         rd_pend = pend_q[rd_addr[gi]];
         if (wb_hit) begin
            rd_val  = rf.wb_data;
            rd_pend = 1'b0;
         end else if (wa_hit) begin
            rd_val  = rf.wa_data;
            rd_pend = 1'b0;
         end
         if (rst || (rd_addr[gi] == '0)) begin
            rd_val  = '0;
            rd_pend = 1'b0;
         end
      end

      assign rd_data[gi] = rd_val;
      assign rd_busy[gi] = rd_pend;
   end

   assign rf.rs1_data = rd_data[0];
   assign rf.rs2_data = rd_data[1];
   assign rf.rs1_busy = rd_busy[0];
   assign rf.rs2_busy = rd_busy[1];
endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: one instance with bypass and one without share the same
// stimulus; a behavioural register/pending model supplies every expected value.
module tb_regfile_sb;
   localparam int XLEN = 32;
   localparam int AW   = 5;
   localparam int NREG = 32;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [AW-1:0]   rs1_addr, rs2_addr, wa_addr, wb_addr, iss_addr;
   logic [XLEN-1:0] wa_data, wb_data;
   logic            wa_en, wb_en, iss_en, flush;

   int checks   = 0;
   int failures = 0;
   int txn      = 0;

   logic [XLEN-1:0] m_regs [NREG];
   bit              m_pend [NREG];

   regfile_sb_if #(.XLEN(XLEN), .AW(AW)) bus_byp ();
   regfile_sb_if #(.XLEN(XLEN), .AW(AW)) bus_nob ();

   assign bus_byp.rs1_addr = rs1_addr;
   assign bus_byp.rs2_addr = rs2_addr;
   assign bus_byp.wa_en    = wa_en;
   assign bus_byp.wa_addr  = wa_addr;
   assign bus_byp.wa_data  = wa_data;
   assign bus_byp.wb_en    = wb_en;
   assign bus_byp.wb_addr  = wb_addr;
   assign bus_byp.wb_data  = wb_data;
   assign bus_byp.iss_en   = iss_en;
   assign bus_byp.iss_addr = iss_addr;
   assign bus_byp.flush    = flush;

   assign bus_nob.rs1_addr = rs1_addr;
   assign bus_nob.rs2_addr = rs2_addr;
   assign bus_nob.wa_en    = wa_en;
   assign bus_nob.wa_addr  = wa_addr;
   assign bus_nob.wa_data  = wa_data;
   assign bus_nob.wb_en    = wb_en;
   assign bus_nob.wb_addr  = wb_addr;
   assign bus_nob.wb_data  = wb_data;
   assign bus_nob.iss_en   = iss_en;
   assign bus_nob.iss_addr = iss_addr;
   assign bus_nob.flush    = flush;

   regfile_sb #(.XLEN(XLEN), .AW(AW), .BYPASS(1)) dut_byp (
      .clk (clk),
      .rst (rst),
      .rf  (bus_byp)
   );

   regfile_sb #(.XLEN(XLEN), .AW(AW), .BYPASS(0)) dut_nob (
      .clk (clk),
      .rst (rst),
      .rf  (bus_nob)
   );

   always #5 clk = ~clk;

   function automatic logic [XLEN-1:0] exp_data(bit byp, logic [AW-1:0] a);
      if (rst || a == '0) return '0;
      if (byp && wb_en && wb_addr == a) return wb_data;
      if (byp && wa_en && wa_addr == a) return wa_data;
      return m_regs[a];
   endfunction

   function automatic logic exp_busy(bit byp, logic [AW-1:0] a);
      if (rst || a == '0) return 1'b0;
      if (byp && ((wa_en && wa_addr == a) || (wb_en && wb_addr == a))) return 1'b0;
      return m_pend[a];
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NREG; i++) begin
         m_regs[i] = '0;
         m_pend[i] = 1'b0;
      end
   endtask

   // Apply rules lowest priority first so the higher ones overwrite.
   task automatic model_edge();
      if (wa_en) m_pend[wa_addr] = 1'b0;
      if (wb_en) m_pend[wb_addr] = 1'b0;
      if (flush) for (int i = 0; i < NREG; i++) m_pend[i] = 1'b0;
      if (iss_en) m_pend[iss_addr] = 1'b1;
      if (wa_en) m_regs[wa_addr] = wa_data;
      if (wb_en) m_regs[wb_addr] = wb_data;
      m_pend[0] = 1'b0;
      m_regs[0] = '0;
   endtask

   task automatic check(string tag, logic [XLEN-1:0] obs, logic [XLEN-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h (txn %0d)", tag, obs, exp, txn);
      end
   endtask

   task automatic check_all();
      check("byp.rs1_data", bus_byp.rs1_data, exp_data(1'b1, rs1_addr));
      check("byp.rs2_data", bus_byp.rs2_data, exp_data(1'b1, rs2_addr));
      check("byp.rs1_busy", XLEN'(bus_byp.rs1_busy), XLEN'(exp_busy(1'b1, rs1_addr)));
      check("byp.rs2_busy", XLEN'(bus_byp.rs2_busy), XLEN'(exp_busy(1'b1, rs2_addr)));
      check("nob.rs1_data", bus_nob.rs1_data, exp_data(1'b0, rs1_addr));
      check("nob.rs2_data", bus_nob.rs2_data, exp_data(1'b0, rs2_addr));
      check("nob.rs1_busy", XLEN'(bus_nob.rs1_busy), XLEN'(exp_busy(1'b0, rs1_addr)));
      check("nob.rs2_busy", XLEN'(bus_nob.rs2_busy), XLEN'(exp_busy(1'b0, rs2_addr)));
   endtask

   task automatic settle();
      @(negedge clk);
      check_all();
   endtask

   task automatic advance();
      @(posedge clk);
      $display("txn %0d rst=%0b rs=%0d/%0d wa=%0b/%0d/%h wb=%0b/%0d/%h iss=%0b/%0d flush=%0b",
               txn, rst, rs1_addr, rs2_addr, wa_en, wa_addr, wa_data,
               wb_en, wb_addr, wb_data, iss_en, iss_addr, flush);
      if (!rst) model_edge();
      txn++;
      #1;
   endtask

   task automatic idle_inputs();
      wa_en = 1'b0; wa_addr = '0; wa_data = '0;
      wb_en = 1'b0; wb_addr = '0; wb_data = '0;
      iss_en = 1'b0; iss_addr = '0; flush = 1'b0;
   endtask

   function automatic logic [AW-1:0] rand_addr();
      if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, NREG - 1));
      return AW'($urandom_range(0, 7));
   endfunction

   initial begin
      model_reset();
      idle_inputs();
      rs1_addr = '0;
      rs2_addr = '0;

      // Held in reset with a live bypass request: outputs stay zero.
      rs1_addr = 5'd3; wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'hA5A5A5A5;
      settle();
      check("rst_bypass_data", bus_byp.rs1_data, 32'h0);
      advance();
      rst = 1'b0;
      idle_inputs();

      // x0: writes and issues are ignored.
      rs1_addr = '0; wb_en = 1'b1; wb_addr = '0; wb_data = 32'hFFFFFFFF;
      iss_en = 1'b1; iss_addr = '0;
      settle();
      check("x0_data_same", bus_byp.rs1_data, 32'h0);
      check("x0_busy_same", XLEN'(bus_byp.rs1_busy), 32'h0);
      advance();
      idle_inputs();
      settle();
      check("x0_data_next", bus_nob.rs1_data, 32'h0);
      advance();

      // Dual write to the same register: lane B wins.
      rs1_addr = 5'd7;
      wa_en = 1'b1; wa_addr = 5'd7; wa_data = 32'h11111111;
      wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h22222222;
      settle();
      check("dual_byp_same", bus_byp.rs1_data, 32'h22222222);
      advance();
      idle_inputs();
      settle();
      check("dual_byp_next", bus_byp.rs1_data, 32'h22222222);
      check("dual_nob_next", bus_nob.rs1_data, 32'h22222222);
      advance();

      // Bypass through lane A.
      rs2_addr = 5'd3;
      wa_en = 1'b1; wa_addr = 5'd3; wa_data = 32'h12345678;
      settle();
      check("bypass_byp_same", bus_byp.rs2_data, 32'h12345678);
      check("bypass_nob_same", bus_nob.rs2_data, 32'h0);
      advance();
      idle_inputs();
      settle();
      check("bypass_nob_next", bus_nob.rs2_data, 32'h12345678);
      advance();

      // Scoreboard lifetime of a single producer.
      rs1_addr = 5'd9; iss_en = 1'b1; iss_addr = 5'd9;
      settle();
      advance();
      idle_inputs();
      for (int c = 1; c <= 3; c++) begin
         settle();
         check("sb_busy_byp", XLEN'(bus_byp.rs1_busy), 32'h1);
         check("sb_busy_nob", XLEN'(bus_nob.rs1_busy), 32'h1);
         advance();
      end
      wb_en = 1'b1; wb_addr = 5'd9; wb_data = $urandom;
      settle();
      check("sb_wb_byp", XLEN'(bus_byp.rs1_busy), 32'h0);
      check("sb_wb_nob", XLEN'(bus_nob.rs1_busy), 32'h1);
      advance();
      idle_inputs();
      settle();
      check("sb_after_nob", XLEN'(bus_nob.rs1_busy), 32'h0);
      advance();
      iss_en = 1'b1; iss_addr = 5'd9; wb_en = 1'b1; wb_addr = 5'd9; wb_data = $urandom;
      settle();
      advance();
      idle_inputs();
      settle();
      check("sb_iss_wins_byp", XLEN'(bus_byp.rs1_busy), 32'h1);
      check("sb_iss_wins_nob", XLEN'(bus_nob.rs1_busy), 32'h1);
      advance();

      // Flush clears older producers but not one issued in the same cycle.
      for (int k = 0; k < 3; k++) begin
         iss_en = 1'b1; iss_addr = AW'(4 + 2 * k);
         settle();
         advance();
      end
      iss_en = 1'b1; iss_addr = 5'd10; flush = 1'b1;
      settle();
      advance();
      idle_inputs();
      rs1_addr = 5'd4; rs2_addr = 5'd10;
      settle();
      check("flush_x4", XLEN'(bus_byp.rs1_busy), 32'h0);
      check("flush_x10", XLEN'(bus_nob.rs2_busy), 32'h1);
      advance();
      rs1_addr = 5'd6; rs2_addr = 5'd8;
      settle();
      advance();

      // Asynchronous reset in the middle of a cycle.
      wa_en = 1'b1; wa_addr = 5'd5; wa_data = 32'hDEADBEEF;
      settle();
      advance();
      idle_inputs();
      iss_en = 1'b1; iss_addr = 5'd5;
      settle();
      advance();
      idle_inputs();
      rs1_addr = 5'd5;
      settle();
      check("pre_rst_data", bus_nob.rs1_data, 32'hDEADBEEF);
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      check_all();
      check("rst_async_data", bus_byp.rs1_data, 32'h0);
      check("rst_async_busy", XLEN'(bus_nob.rs1_busy), 32'h0);
      wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'hCAFEF00D;
      #1;
      check_all();
      advance();
      rst = 1'b0;
      idle_inputs();
      settle();
      check("post_rst_data", bus_byp.rs1_data, 32'h0);
      check("post_rst_busy", XLEN'(bus_byp.rs1_busy), 32'h0);
      advance();

      // Randomised traffic against the model.
      for (int n = 0; n < 400; n++) begin
         rs1_addr = rand_addr();
         rs2_addr = rand_addr();
         wa_en    = 1'($urandom_range(0, 1));
         wa_addr  = rand_addr();
         wa_data  = $urandom;
         wb_en    = 1'($urandom_range(0, 1));
         wb_addr  = rand_addr();
         wb_data  = $urandom;
         iss_en   = ($urandom_range(0, 2) == 0);
         iss_addr = rand_addr();
         flush    = ($urandom_range(0, 15) == 0);
         settle();
         advance();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised multi-port integer register file with same-cycle write-to-read bypass and a per-register pending (scoreboard) bit, for the pipelined RISC-V core. It sits in decode/ID: two combinational read ports feed operand muxes, two write ports come from the writeback lanes, and the scoreboard reports in-flight producers to the hazard unit. Register 0 is hardwired to zero and is never pending.

## Interface
- XLEN, 32, data width in bits (≥8)
- AW, 5, address width; NREG = 2**AW registers (AW ≥ 1)
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = reads see stored value only
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- rs1_addr, rs2_addr  in  AW  read addresses
- rs1_data, rs2_data  out  XLEN  read data (combinational)
- rs1_busy, rs2_busy  out  1  addressed register has a pending producer (combinational)
- wa_en, wa_addr, wa_data  in  1/AW/XLEN  write port A (lower priority)
- wb_en, wb_addr, wb_data  in  1/AW/XLEN  write port B (higher priority)
- iss_en, iss_addr  in  1/AW  issue: mark iss_addr pending
- flush  in  1  clear all pending bits (pipeline flush)

## Operation
- Storage: regs[1..NREG-1] of XLEN bits, pend[1..NREG-1] bits; index 0 has no storage.
- Write: on clk rise, if wX_en and wX_addr≠0, regs[wX_addr] ← wX_data. Both ports same nonzero address: port B value stored; port A dropped.
- Read: rsN_data = 0 if rsN_addr = 0. Else if BYPASS=1 and wb_en and wb_addr = rsN_addr: wb_data. Else if BYPASS=1 and wa_en and wa_addr = rsN_addr: wa_data. Else regs[rsN_addr].
- Scoreboard update per clock, per register r≠0, priority high→low:
  - iss_en and iss_addr = r → pend[r] ← 1 (new producer wins over same-cycle writeback and flush)
  - flush → pend[r] ← 0
  - (wa_en and wa_addr = r) or (wb_en and wb_addr = r) → pend[r] ← 0
  - else hold.
- Writes update regs regardless of pend state; no ordering check inside the block.
- rsN_busy = 0 if rsN_addr = 0. Else pend[rsN_addr], except when BYPASS=1 and a write to rsN_addr is enabled this cycle → 0 (data is available via bypass). With BYPASS=0, busy reflects pend only.
- iss_en with iss_addr = 0: ignored. Writes to address 0: ignored, no bypass.

## Timing
- Reset (async assert, any time incl. mid-write): all regs ← 0, all pend ← 0 immediately; while rst=1, all writes, issues and flush are ignored, rsN_data = 0, rsN_busy = 0 for all addresses regardless of bypass inputs.
- First state update on first rising clk edge after rst deasserts.
- Read latency: 0 cycles (combinational from address and write inputs). Write latency: stored value visible via regs path the cycle after the edge; via bypass in the same cycle.
- Scoreboard: iss in cycle n → busy = 1 from cycle n+1 until a write to that address (busy drops in the write cycle if BYPASS=1, cycle after if BYPASS=0).
- No handshake; all inputs sampled every edge, single-cycle pulses valid.
- Area: two NREG:1 read muxes plus bypass compare; no combinational path from outputs to inputs.

## Test plan
- Reset: pre-write regs[5]=0xDEADBEEF, issue x5, assert rst mid-cycle → rs1_data=0, rs1_busy=0 immediately; after release rs1_addr=5 reads 0, busy 0.
- x0: wb_en=1, wb_addr=0, wb_data=0xFFFFFFFF, iss_addr=0 → rs1_addr=0 reads 0, busy 0 in same and next cycle.
- Dual-write conflict: wa=(7,0x11111111), wb=(7,0x22222222) same cycle → BYPASS=1 same-cycle read 0x22222222; next cycle stored 0x22222222.
- Bypass: write x3=0x12345678 via wa while rs2_addr=3 → BYPASS=1: rs2_data=0x12345678 same cycle; BYPASS=0: old value same cycle, new value next cycle.
- Scoreboard: iss x9 cycle 0 → rs1_busy=1 cycles 1–3; wb x9 cycle 4 → busy 0 in cycle 4 (BYPASS=1) / cycle 5 (BYPASS=0); iss x9 and wb x9 same cycle → busy stays 1 next cycle.
- Flush: iss x4, x6, x8 in consecutive cycles, then flush with iss x10 same cycle → x4/x6/x8 busy 0, x10 busy 1 next cycle.
